// File: rtl/counter_pkg.sv
// Shared encodings for the counter arbiter: counter modes, FSM states and the
// next-count function used by the step counter.
package counter_pkg;

    localparam int STEP_W_DEF = 4;

    typedef enum logic [1:0] {
        MODE_UP4 = 2'b00,
        MODE_DN4 = 2'b01,
        MODE_UP3 = 2'b10,
        MODE_DN3 = 2'b11
    } cnt_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } arb_state_e;

    // The mod-3 modes never produce 11 themselves; if it appears it falls back to 00.
    function automatic logic [1:0] next_count(input logic [1:0] cur, input logic [1:0] mode);
        logic [1:0] nxt;
        nxt = 2'b00;
        case (mode)
            MODE_UP4: nxt = cur + 2'd1;
            MODE_DN4: nxt = cur - 2'd1;
            MODE_UP3: begin
                case (cur)
                    2'b00:   nxt = 2'b01;
                    2'b01:   nxt = 2'b10;
                    default: nxt = 2'b00;
                endcase
            end
            default: begin
                case (cur)
                    2'b00:   nxt = 2'b10;
                    2'b10:   nxt = 2'b01;
                    default: nxt = 2'b00;
                endcase
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mode_counter.sv
// 2-bit counter that advances one step per enabled clock in the selected mode.
module mode_counter
    import counter_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] mode,
    output logic [1:0] q
);

    logic [1:0] q_d;
    logic [1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = next_count(q_q, mode);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= 2'b00;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/counter_arbiter.sv
// Two-requester round-robin arbiter that lends a shared mode counter to the
// winner for a requested number of steps.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | counter free; any request is granted on the next edge
//   RUN     | owner holds the counter; one step per clock
//   DONE    | one-cycle done or abort pulse, grant cleared, pointer moved
module counter_arbiter
    import counter_pkg::*;
#(
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        req,
    input  logic [1:0]        mode0,
    input  logic [1:0]        mode1,
    input  logic [STEP_W-1:0] steps0,
    input  logic [STEP_W-1:0] steps1,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              done,
    output logic              abort,
    output logic [1:0]        q,
    output logic [1:0]        mode
);

    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    arb_state_e        state_d, state_q;
    logic [1:0]        grant_d, grant_q;
    logic              busy_d, busy_q;
    logic              done_d, done_q;
    logic              abort_d, abort_q;
    logic [1:0]        mode_d, mode_q;
    logic [STEP_W-1:0] remaining_d, remaining_q;
    logic              prio_d, prio_q;
    logic              owner_d, owner_q;
    logic              cnt_en;
    logic              win;
    logic [STEP_W-1:0] win_steps;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        mode_d      = mode_q;
        remaining_d = remaining_q;
        prio_d      = prio_q;
        owner_d     = owner_q;
        cnt_en      = 1'b0;
        win         = (req == 2'b11) ? prio_q : req[1];
        win_steps   = win ? steps1 : steps0;

        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    owner_d = win;
                    mode_d  = win ? mode1 : mode0;
                    if (win_steps == '0) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        grant_d     = 2'b00;
                        busy_d      = 1'b0;
                        remaining_d = '0;
                    end else begin
                        state_d     = ST_RUN;
                        grant_d     = {win, ~win};
                        busy_d      = 1'b1;
                        remaining_d = win_steps;
                    end
                end
            end
            ST_RUN: begin
                // A dropped request wins over the final step: q is left untouched.
                if (!req[owner_q]) begin
                    state_d = ST_DONE;
                    abort_d = 1'b1;
                    grant_d = 2'b00;
                    busy_d  = 1'b0;
                end else begin
                    cnt_en      = 1'b1;
                    remaining_d = remaining_q - STEP_ONE;
                    if (remaining_q == STEP_ONE) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        grant_d = 2'b00;
                        busy_d  = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                prio_d  = ~owner_q;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            mode_q      <= 2'b00;
            remaining_q <= '0;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            mode_q      <= mode_d;
            remaining_q <= remaining_d;
            prio_q      <= prio_d;
            owner_q     <= owner_d;
        end
    end

    mode_counter u_mode_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (cnt_en),
        .mode    (mode_q),
        .q       (q)
    );

    assign grant = grant_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign abort = abort_q;
    assign mode  = mode_q;

endmodule
